// File: rtl/key_event_pkg.sv
// Shared types and constants for the keypad event debouncer and its event FIFO.
// Events are {is_release, code[3:0]}; raw key words are {valid, code[3:0]}.
package key_event_pkg;

  localparam int KEY_W         = 5;
  localparam int CODE_W        = 4;
  localparam int KEY_VALID_BIT = 4;
  localparam int FIFO_DEPTH    = 4;
  localparam int FIFO_PTR_W    = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W    = $clog2(FIFO_DEPTH + 1);

  localparam logic EV_PRESS   = 1'b0;
  localparam logic EV_RELEASE = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } key_state_e;

  typedef struct packed {
    key_state_e              state;
    logic [FIFO_CNT_W-1:0]   fifo_count;
  } key_event_dbg_t;

  function automatic logic [KEY_W-1:0] make_event(input logic is_release,
                                                  input logic [CODE_W-1:0] code);
    return {is_release, code};
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Four-entry show-ahead event FIFO; head is driven combinationally from storage.
// A push into a full FIFO succeeds only when the same cycle pops, otherwise it is dropped.
module key_event_fifo
  import key_event_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [KEY_W-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [KEY_W-1:0]      rdata_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic                  drop_o
);

  logic [KEY_W-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q;
  logic [FIFO_PTR_W-1:0] rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + FIFO_PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_debouncer.sv
// Debounces the keypad scanner word against a slow tick and queues press (and
// optionally release) events. Handshake: ev_valid=1 means ev_data holds the oldest
// event; ev_rd pops it at the clock edge and is ignored while ev_valid=0.
module key_event_debouncer
  import key_event_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_CNT     = 20,
  parameter bit REPORT_RELEASE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [KEY_W-1:0] key_in,
  output logic             ev_valid,
  output logic [KEY_W-1:0] ev_data,
  input  logic             ev_rd,
  output logic             fifo_full,
  output logic             overflow,
  input  logic             clr_overflow,
  output key_event_dbg_t   dbg
);

  localparam int TCNT_W = $clog2(TICK_DIV);
  localparam int DCNT_W = $clog2(STABLE_CNT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(STABLE_CNT - 1);

  logic [KEY_W-1:0]      key_q;
  logic [TCNT_W-1:0]     tcnt_q;
  logic [DCNT_W-1:0]     dcnt_q;
  logic [CODE_W-1:0]     cand_q;
  key_state_e            state_q;
  logic                  overflow_q;

  logic                  tick;
  logic                  cand_match;
  logic                  window_done;
  logic                  ev_push;
  logic [KEY_W-1:0]      ev_push_data;
  logic                  fifo_empty;
  logic                  fifo_drop;
  logic [FIFO_CNT_W-1:0] fifo_count;

  // key_in is unrelated to the debounce window, so it is sampled once here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key_q <= '0;
    else          key_q <= key_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              tcnt_q <= '0;
    else if (tcnt_q == TCNT_LAST) tcnt_q <= '0;
    else                       tcnt_q <= tcnt_q + TCNT_W'(1);
  end

  assign tick        = (tcnt_q == TCNT_LAST);
  assign cand_match  = (key_q == {1'b1, cand_q});
  assign window_done = tick && (dcnt_q == DCNT_LAST);

  // Event pushes are decoded from the current state so an accepted key reaches
  // the FIFO in the same cycle the FSM commits to HELD or IDLE.
  always_comb begin
    ev_push      = 1'b0;
    ev_push_data = make_event(EV_PRESS, cand_q);
    case (state_q)
      DEB_PRESS: ev_push = cand_match && window_done;
      DEB_REL: begin
        ev_push      = REPORT_RELEASE && !cand_match && window_done;
        ev_push_data = make_event(EV_RELEASE, cand_q);
      end
      default: ev_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      cand_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_q[KEY_VALID_BIT]) begin
            state_q <= DEB_PRESS;
            cand_q  <= key_q[CODE_W-1:0];
            dcnt_q  <= '0;
          end
        end
        DEB_PRESS: begin
          if (!cand_match) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
          end else if (tick) begin
            if (dcnt_q == DCNT_LAST) begin
              state_q <= HELD;
              dcnt_q  <= '0;
            end else begin
              dcnt_q <= dcnt_q + DCNT_W'(1);
            end
          end
        end
        HELD: begin
          // A different key counts as a release; it must debounce out first.
          if (!cand_match) begin
            state_q <= DEB_REL;
            dcnt_q  <= '0;
          end
        end
        DEB_REL: begin
          if (cand_match) begin
            state_q <= HELD;
            dcnt_q  <= '0;
          end else if (tick) begin
            if (dcnt_q == DCNT_LAST) begin
              state_q <= IDLE;
              dcnt_q  <= '0;
            end else begin
              dcnt_q <= dcnt_q + DCNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          dcnt_q  <= '0;
        end
      endcase
    end
  end

  key_event_fifo u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (ev_push),
    .wdata_i (ev_push_data),
    .pop_i   (ev_rd),
    .rdata_o (ev_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  // A drop in the same cycle as a clear must stay visible to software.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          overflow_q <= 1'b0;
    else if (fifo_drop)    overflow_q <= 1'b1;
    else if (clr_overflow) overflow_q <= 1'b0;
  end

  assign overflow       = overflow_q;
  assign ev_valid       = !fifo_empty;
  assign dbg.state      = state_q;
  assign dbg.fifo_count = fifo_count;

endmodule

// File: doc/key_event_debouncer.md
# key_event_debouncer

Downstream stage of the 4x4 keypad scanner: consumes its raw 5-bit key word (bit 4 = key-valid, bits 3:0 = key code), debounces it against a slow tick, and turns stable presses (and optionally releases) into discrete events. Events are queued in a 4-deep show-ahead FIFO read by the Nios II PIO/avalon glue, so the CPU never sees bounce or repeated codes while a key is held.

## Interface

Parameters:
- TICK_DIV, 50000: clk cycles per debounce tick (1 ms at 50 MHz); legal range ≥2.
- STABLE_CNT, 20: consecutive ticks a key state must hold before it is accepted; legal range ≥2.
- REPORT_RELEASE, 0: 1 = also queue release events.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- key_in  in  5  raw scanner word {valid, code[3:0]}; asynchronous to the debounce window
- ev_valid  out  1  FIFO non-empty; reset 0
- ev_data  out  5  FIFO head {is_release, code[3:0]}; reset 5'b0
- ev_rd  in  1  pop head; honoured only when ev_valid=1
- fifo_full  out  1  4 entries held; reset 0
- overflow  out  1  sticky: event dropped on full FIFO; reset 0
- clr_overflow  in  1  clears overflow

## Operation

- key_in registered once (key_q, reset 5'b0); all decisions use key_q.
- Tick counter tcnt: 0..TICK_DIV-1, wraps; tick=1 for the one cycle tcnt==TICK_DIV-1. Free-running from reset.
- Debounce counter dcnt, width $clog2(STABLE_CNT); candidate register cand[3:0].
- FSM (reset IDLE, dcnt=0, cand=0):
  - IDLE: key_q[4]=1 -> DEB_PRESS, cand<=key_q[3:0], dcnt<=0.
  - DEB_PRESS: key_q != {1,cand} -> IDLE, dcnt<=0. Else on tick: dcnt==STABLE_CNT-1 -> push {0,cand}, HELD; otherwise dcnt++.
  - HELD: key_q != {1,cand} (release or different key) -> DEB_REL, dcnt<=0.
  - DEB_REL: key_q=={1,cand} -> HELD (bounce absorbed, no event). Else on tick: dcnt==STABLE_CNT-1 -> IDLE, push {1,cand} if REPORT_RELEASE; otherwise dcnt++.
- A different key pressed while HELD is accepted only after full release debounce, then a fresh press debounce from IDLE.
- FIFO: 4 entries, show-ahead; ev_data = head combinationally from storage.
  - push & !full -> write; push & full & !pop -> drop, overflow<=1.
  - push & pop same cycle when full -> both succeed, no overflow; when empty -> pop ignored, push succeeds.
  - ev_rd with ev_valid=0 ignored.
- overflow: set has priority over clr_overflow in the same cycle.

## Timing

- key_in to key_q: 1 cycle.
- Press acceptance: STABLE_CNT ticks of stable key_q; first tick may be partial, so delay is (STABLE_CNT-1)*TICK_DIV+1 .. STABLE_CNT*TICK_DIV cycles after key_q settles.
- Push in cycle N -> ev_valid=1 and ev_data valid in cycle N+1.
- Pop in cycle N -> next head (or ev_valid=0) in cycle N+1.
- reset_n low at any point: FSM, counters, FIFO pointers and all outputs to reset values immediately; partially debounced key discarded.

## Structure

- Package key_event_pkg: FSM state enum (IDLE, DEB_PRESS, HELD, DEB_REL), KEY_VALID_BIT=4, EV_PRESS=1'b0, EV_RELEASE=1'b1, FIFO_DEPTH=4.
- Sub-module key_event_fifo (5-bit x 4, show-ahead, full/empty, 3-bit count); debouncer FSM and tick counter in the top.

## Test plan

- TICK_DIV=4, STABLE_CNT=3: key_in=5'h15 held 20 cycles -> exactly one event, ev_data=5'h05, ev_valid within 13 cycles of key_q change.
- Bounce: 5'h15 toggled to 5'h00 every 5 cycles for 40 cycles, then stable -> single event 5'h05 only after stable period; none during bounce.
- REPORT_RELEASE=1: press 5'h1A, hold, release to 5'h00 -> events 5'h0A then 5'h1A, in order.
- No reads, five distinct debounced presses 0..4 -> fifo_full=1 after fourth, overflow=1 after fifth; reads return 5'h00..5'h03; clr_overflow -> overflow=0.
- Full FIFO, push and ev_rd same cycle -> fifo_full stays 1, overflow stays 0, head advances.
- reset_n pulsed low mid-DEB_PRESS with key held -> ev_valid=0, FIFO empty; after release of reset, event appears only after full fresh debounce.
